// File: rtl/atom_cfg_loader_pkg.sv
// Shared types, FSM states and W0 field layout for the atom configuration loader.
package atom_cfg_loader_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    typedef enum logic [1:0] {
        S_W0   = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_PEND = 2'd3
    } state_t;

    // Control word field offsets; bits above CTRL_W are ignored.
    localparam int CTRL_W      = 8;
    localparam int W0_SEL1_BIT = 0;
    localparam int W0_SEL2_LSB = 1;
    localparam int W0_SEL3_BIT = 3;
    localparam int W0_SEL4_LSB = 4;
    localparam int W0_REL_LSB  = 6;

    // Relational opcode encodings.
    localparam int2_t REL_NE = 2'd0;
    localparam int2_t REL_LT = 2'd1;
    localparam int2_t REL_GT = 2'd2;
    localparam int2_t REL_EQ = 2'd3;

endpackage

// File: rtl/atom_cfg_shadow.sv
// Shadow/active register pair: frames load the shadow, a commit copies it to the active copy.
module atom_cfg_shadow #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic         commit_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] active_o
);

    logic [W-1:0] shadow_q;
    logic [W-1:0] active_q;

    // Shadow captures accepted words; a framing error wipes it so nothing stale survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (clear_i) begin
            shadow_q <= '0;
        end else if (load_i) begin
            shadow_q <= data_i;
        end
    end

    // Active copy only changes on commit, so the datapath never sees a half-written frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else if (commit_i) begin
            active_q <= shadow_q;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/atom_cfg_loader.sv
// Control-plane loader for a stateful atom: 3-word frames are staged in shadows and
// committed atomically when no packet occupies the atom.
// Optional feature: define ATOM_CFG_READBACK_EN to add the rd_sel/rd_data readback port.
module atom_cfg_loader
    import atom_cfg_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [31:0]  cfg_data,
    input  logic         cfg_last,
    input  logic         pkt_valid,
    output logic         sel_1,
    output logic [1:0]   sel_2,
    output logic         sel_3,
    output logic [1:0]   sel_4,
    output logic [1:0]   rel_opcode,
    output logic [31:0]  cons_1,
    output logic [31:0]  cons_2,
    output logic         cfg_applied,
    output logic         cfg_err,
    input  logic         err_clr,
    output logic [7:0]   commit_cnt
`ifdef ATOM_CFG_READBACK_EN
    ,
    input  logic [1:0]   rd_sel,
    output logic [31:0]  rd_data
`endif
);

    state_t              state_q, state_d;
    logic                cfgApplied_q;
    logic                cfgErr_q, cfgErr_d;
    logic [7:0]          commitCnt_q, commitCnt_d;
    bool                 accept;
    bool                 loadCtrl, loadCons1, loadCons2, commit, frameErr;
    logic [CTRL_W-1:0]   ctrlActive;
    int32_t              cons1Active, cons2Active;

    assign cfg_ready = (state_q != S_PEND);
    assign accept    = cfg_valid && cfg_ready;

    // Frame sequencing: decide which shadow loads, whether the frame is malformed, and when to commit.
    always_comb begin
        state_d   = state_q;
        loadCtrl  = 1'b0;
        loadCons1 = 1'b0;
        loadCons2 = 1'b0;
        commit    = 1'b0;
        frameErr  = 1'b0;
        case (state_q)
            S_W0: begin
                if (accept) begin
                    if (cfg_last) begin
                        frameErr = 1'b1;
                    end else begin
                        loadCtrl = 1'b1;
                        state_d  = S_W1;
                    end
                end
            end
            S_W1: begin
                if (accept) begin
                    if (cfg_last) begin
                        frameErr = 1'b1;
                        state_d  = S_W0;
                    end else begin
                        loadCons1 = 1'b1;
                        state_d   = S_W2;
                    end
                end
            end
            S_W2: begin
                if (accept) begin
                    if (!cfg_last) begin
                        frameErr = 1'b1;
                        state_d  = S_W0;
                    end else begin
                        loadCons2 = 1'b1;
                        state_d   = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (!pkt_valid) begin
                    commit  = 1'b1;
                    state_d = S_W0;
                end
            end
            default: state_d = S_W0;
        endcase
    end

    // Sticky error and commit counter next-state; a fresh error beats a simultaneous clear.
    always_comb begin
        cfgErr_d    = cfgErr_q;
        commitCnt_d = commitCnt_q;
        if (frameErr) begin
            cfgErr_d = 1'b1;
        end else if (err_clr) begin
            cfgErr_d = 1'b0;
        end
        if (commit) begin
            commitCnt_d = commitCnt_q + 8'd1;
        end
    end

    // Loader state, applied pulse, error flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_W0;
            cfgApplied_q <= 1'b0;
            cfgErr_q     <= 1'b0;
            commitCnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cfgApplied_q <= commit;
            cfgErr_q     <= cfgErr_d;
            commitCnt_q  <= commitCnt_d;
        end
    end

    atom_cfg_shadow #(.W(CTRL_W)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (loadCtrl),
        .clear_i  (frameErr),
        .commit_i (commit),
        .data_i   (cfg_data[CTRL_W-1:0]),
        .active_o (ctrlActive)
    );

    atom_cfg_shadow #(.W(32)) u_cons1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (loadCons1),
        .clear_i  (frameErr),
        .commit_i (commit),
        .data_i   (cfg_data),
        .active_o (cons1Active)
    );

    atom_cfg_shadow #(.W(32)) u_cons2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (loadCons2),
        .clear_i  (frameErr),
        .commit_i (commit),
        .data_i   (cfg_data),
        .active_o (cons2Active)
    );

    assign sel_1       = ctrlActive[W0_SEL1_BIT];
    assign sel_2       = ctrlActive[W0_SEL2_LSB +: 2];
    assign sel_3       = ctrlActive[W0_SEL3_BIT];
    assign sel_4       = ctrlActive[W0_SEL4_LSB +: 2];
    assign rel_opcode  = ctrlActive[W0_REL_LSB +: 2];
    assign cons_1      = cons1Active;
    assign cons_2      = cons2Active;
    assign cfg_applied = cfgApplied_q;
    assign cfg_err     = cfgErr_q;
    assign commit_cnt  = commitCnt_q;

`ifdef ATOM_CFG_READBACK_EN
    // Readback mux over the active configuration; control word is repacked with zero upper bits.
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            2'd0:    rd_data = {{(32-CTRL_W){1'b0}}, ctrlActive};
            2'd1:    rd_data = cons1Active;
            2'd2:    rd_data = cons2Active;
            default: rd_data = {24'b0, commitCnt_q};
        endcase
    end
`endif

endmodule

// File: tb/tb_atom_cfg_loader.sv
// Scoreboard bench for atom_cfg_loader: stimulus pushes expected commits, a monitor
// pops and compares on each cfg_applied pulse. Readback checks need ATOM_CFG_READBACK_EN.
module tb_atom_cfg_loader;

    typedef struct {
        logic        s1;
        logic [1:0]  s2;
        logic        s3;
        logic [1:0]  s4;
        logic [1:0]  rel;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        sel_1, sel_3;
    logic [1:0]  sel_2, sel_4, rel_opcode;
    logic [31:0] cons_1, cons_2;
    logic        cfg_applied, cfg_err;
    logic        err_clr = 1'b0;
    logic [7:0]  commit_cnt;
`ifdef ATOM_CFG_READBACK_EN
    logic [1:0]  rd_sel = 2'd0;
    logic [31:0] rd_data;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t expQ[$];

    atom_cfg_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .pkt_valid   (pkt_valid),
        .sel_1       (sel_1),
        .sel_2       (sel_2),
        .sel_3       (sel_3),
        .sel_4       (sel_4),
        .rel_opcode  (rel_opcode),
        .cons_1      (cons_1),
        .cons_2      (cons_2),
        .cfg_applied (cfg_applied),
        .cfg_err     (cfg_err),
        .err_clr     (err_clr),
        .commit_cnt  (commit_cnt)
`ifdef ATOM_CFG_READBACK_EN
        ,
        .rd_sel      (rd_sel),
        .rd_data     (rd_data)
`endif
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word and hold it until the loader accepts it, bounded by a cycle budget.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        bit done = 0;
        cfg_valid = 1'b1;
        cfg_data  = data;
        cfg_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            if (cfg_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic pushExp(input logic s1, input logic [1:0] s2, input logic s3, input logic [1:0] s4,
                           input logic [1:0] rel, input logic [31:0] c1, input logic [31:0] c2,
                           input logic [7:0] cnt);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4; e.rel = rel;
        e.c1 = c1; e.c2 = c2; e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cfg_applied pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && cfg_applied) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_commit", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sel_1", {31'd0, sel_1}, {31'd0, e.s1});
                checkOutput("sel_2", {30'd0, sel_2}, {30'd0, e.s2});
                checkOutput("sel_3", {31'd0, sel_3}, {31'd0, e.s3});
                checkOutput("sel_4", {30'd0, sel_4}, {30'd0, e.s4});
                checkOutput("rel_opcode", {30'd0, rel_opcode}, {30'd0, e.rel});
                checkOutput("cons_1", cons_1, e.c1);
                checkOutput("cons_2", cons_2, e.c2);
                checkOutput("commit_cnt", {24'd0, commit_cnt}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        #12;
        checkOutput("rst_cons_1", cons_1, 32'd0);
        checkOutput("rst_cnt", {24'd0, commit_cnt}, 32'd0);
        checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);
        checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Basic frame: W0=0xC9 -> sel_1=1 sel_2=0 sel_3=1 sel_4=0 rel=3.
        pushExp(1'b1, 2'd0, 1'b1, 2'd0, 2'd3, 32'd5, 32'd7, 8'd1);
        applyStimulus(32'h0000_00C9, 1'b0);
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'd7, 1'b1);
        idle(3);
        checkOutput("single_pulse", {31'd0, cfg_applied}, 32'd0);

        // Commit blocked by pkt_valid for 10 cycles; W0=0x36 -> sel_2=3 sel_4=3 rel=0.
        pkt_valid = 1'b1;
        applyStimulus(32'hFFFF_FF36, 1'b0);
        applyStimulus(32'hAAAA_5555, 1'b0);
        applyStimulus(32'h1234_5678, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_ready", {31'd0, cfg_ready}, 32'd0);
            checkOutput("hold_cons_1", cons_1, 32'd5);
            checkOutput("hold_rel", {30'd0, rel_opcode}, 32'd3);
            idle(1);
        end
        pushExp(1'b0, 2'd3, 1'b0, 2'd3, 2'd0, 32'hAAAA_5555, 32'h1234_5678, 8'd2);
        pkt_valid = 1'b0;
        idle(3);

        // cfg_last on W1 drops the frame and sets the sticky error.
        applyStimulus(32'h0000_00FF, 1'b0);
        applyStimulus(32'hDEAD_BEEF, 1'b1);
        checkOutput("err_w1", {31'd0, cfg_err}, 32'd1);
        checkOutput("err_w1_ready", {31'd0, cfg_ready}, 32'd1);
        idle(3);
        checkOutput("err_w1_nocommit", cons_1, 32'hAAAA_5555);

        // Next valid frame commits normally; W0=0x4A -> sel_2=1 sel_3=1 rel=1.
        pushExp(1'b0, 2'd1, 1'b1, 2'd0, 2'd1, 32'd100, 32'd200, 8'd3);
        applyStimulus(32'h0000_004A, 1'b0);
        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'd200, 1'b1);
        idle(3);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checkOutput("err_clr", {31'd0, cfg_err}, 32'd0);

        // Missing cfg_last on W2 is an error; simultaneous err_clr loses to the new error.
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'd1, 1'b0);
        err_clr = 1'b1;
        applyStimulus(32'd2, 1'b0);
        err_clr = 1'b0;
        checkOutput("err_w2_wins", {31'd0, cfg_err}, 32'd1);
        idle(3);
        checkOutput("err_w2_nocommit", {24'd0, commit_cnt}, 32'd3);

        // cfg_last on W0 is also an error.
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        applyStimulus(32'h0000_0001, 1'b1);
        checkOutput("err_w0", {31'd0, cfg_err}, 32'd1);

        // Reset asserted while pending discards the frame immediately.
        pkt_valid = 1'b1;
        applyStimulus(32'h0000_00C9, 1'b0);
        applyStimulus(32'd9, 1'b0);
        applyStimulus(32'd11, 1'b1);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_cons_1", cons_1, 32'd0);
        checkOutput("arst_cons_2", cons_2, 32'd0);
        checkOutput("arst_rel", {30'd0, rel_opcode}, 32'd0);
        checkOutput("arst_cnt", {24'd0, commit_cnt}, 32'd0);
        checkOutput("arst_err", {31'd0, cfg_err}, 32'd0);
        checkOutput("arst_applied", {31'd0, cfg_applied}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pkt_valid = 1'b0;
        idle(4);
        checkOutput("arst_nocommit", {24'd0, commit_cnt}, 32'd0);

        // 256 back-to-back frames wrap the counter to zero.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] w;
            w = i[7:0];
            pushExp(w[0], w[2:1], w[3], w[5:4], w[7:6], 32'h0000_1000 + i, 32'h00BE_0000 | i,
                    8'(i + 1));
            applyStimulus({24'd0, w}, 1'b0);
            applyStimulus(32'h0000_1000 + i, 1'b0);
            applyStimulus(32'h00BE_0000 | i, 1'b1);
        end
        idle(3);
        checkOutput("wrap_cnt", {24'd0, commit_cnt}, 32'd0);

`ifdef ATOM_CFG_READBACK_EN
        rd_sel = 2'd0; #1;
        checkOutput("rd_ctrl", rd_data, 32'h0000_00FF);
        rd_sel = 2'd1; #1;
        checkOutput("rd_cons_1", rd_data, 32'h0000_10FF);
        rd_sel = 2'd2; #1;
        checkOutput("rd_cons_2", rd_data, 32'h00BE_00FF);
        rd_sel = 2'd3; #1;
        checkOutput("rd_cnt", rd_data, 32'd0);
`endif

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
